char_in: RTL and testbench
==========================

# char_in

Receive-side counterpart of the terminal character output path: accepts characters typed into the external terminal and buffers them for the processor. A character is taken once per rising edge of the terminal-side strobe, stored in a show-ahead FIFO, and popped by the processor-side bus logic with a valid/ack handshake. A sticky overflow flag records characters lost while the FIFO was full.

## Interface
- DEPTH, 16, FIFO capacity in characters; power of two, 2..256
- clk  input  1  system clock; all logic on posedge
- resetn  input  1  asynchronous, active-low reset
- in_char  input  8  character from terminal; sampled in the cycle an in_strobe rising edge is detected
- in_strobe  input  1  terminal strobe; level held high while in_char is presented, one character per low-to-high transition
- char_data  output  8  character at FIFO head; valid only while char_valid=1
- char_valid  output  1  FIFO not empty
- char_ack  input  1  pop FIFO head; ignored when char_valid=0
- char_count  output  $clog2(DEPTH)+1  number of stored characters, 0..DEPTH
- overflow  output  1  sticky; a character was dropped because FIFO was full
- ovf_clear  input  1  clears overflow

## Operation
- Edge detect: register strobe_q <= in_strobe each cycle; push request = in_strobe & ~strobe_q. A strobe held high for many cycles yields exactly one push.
- strobe_q resets to 1: a strobe already high when resetn deasserts is not captured; the next full low-to-high transition is.
- FIFO: DEPTH x 8 storage, write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), count register $clog2(DEPTH)+1 bits.
- Show-ahead: char_data = mem[rd_ptr] combinationally; char_valid = (count != 0).
- Pop = char_ack & char_valid. Push accepted = push request & (count < DEPTH | pop).
- Count update: push only +1; pop only -1; both or neither: unchanged.
- Full and push request with no pop: character dropped, pointers and count unchanged, overflow set.
- Full with simultaneous push request and pop: both happen, count stays DEPTH, no overflow.
- Empty with push request: stored; no same-cycle bypass to char_data.
- Overflow: set on a dropped character; cleared by ovf_clear; set wins if both in the same cycle.
- Storage contents are not reset; only pointers, count, overflow, strobe_q.

## Timing
- Reset values: char_valid=0, char_count=0, overflow=0, char_data undefined (don't-care while char_valid=0), strobe_q=1, pointers=0.
- Reset is asynchronous: asserting resetn mid-operation empties the FIFO immediately; stored characters are discarded.
- Push latency: in_strobe rises before posedge N (strobe_q=0 at that edge) -> char written at edge N -> char_valid=1 and char_data valid after edge N. One cycle from strobe edge to visibility.
- Pop: char_ack high at posedge M with char_valid=1 -> head advances at edge M; next character (or char_valid=0) visible after edge M. Back-to-back pops every cycle permitted.
- char_count and overflow are registered; they update at the same edge as the push/pop/drop that changes them.
- in_char must be stable in the cycle the edge is detected; no further sampling afterwards.

## Test plan
- Reset then single char: in_strobe 0->1 with in_char=0x41, held 5 cycles -> exactly one entry; char_valid=1 one cycle after edge, char_data=0x41, char_count=1; char_ack one cycle -> char_valid=0, count=0.
- Ordering and wrap: push 0x30..0x39 (10 chars), pop 6, push 0x3A..0x45 (12 chars), pop all -> data read in push order 0x30..0x45, count returns 0, overflow=0 (pointers wrap at DEPTH=16).
- Overflow: push 17 chars 0x00..0x10 without popping -> count=16, overflow=1, popping yields 0x00..0x0F only; ovf_clear pulse -> overflow=0; ovf_clear coincident with another drop -> overflow stays 1.
- Full with simultaneous push and pop: fill 16, then strobe edge with in_char=0xAA and char_ack same cycle -> count stays 16, overflow=0, 0xAA is the last char read.
- Strobe across reset: in_strobe high while resetn asserted and released -> no entry; strobe low then high with 0x55 -> one entry 0x55.
- Reset mid-operation: with 5 entries, assert resetn asynchronously between edges -> char_valid=0, char_count=0 immediately; after release a new push is read correctly.

Source files
------------

// File: rtl/char_in.sv
// Terminal receive path: detects in_strobe rising edges, buffers characters in a
// show-ahead FIFO for the processor, and flags characters dropped while full.
module char_in #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [7:0]                 in_char,
   input  logic                       in_strobe,
   output logic [7:0]                 char_data,
   output logic                       char_valid,
   input  logic                       char_ack,
   output logic [$clog2(DEPTH):0]     char_count,
   output logic                       overflow,
   input  logic                       ovf_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          strobe_q;

   logic push_req;
   logic pop;
   logic full;
   logic push;
   logic drop;

   always_comb begin
      push_req = in_strobe & ~strobe_q;
      pop      = char_ack & (count != '0);
      full     = (count == CW'(DEPTH));
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   // strobe_q resets high so a strobe already asserted at reset release is ignored
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         strobe_q <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         strobe_q <= in_strobe;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clear)
            overflow <= 1'b0;
      end
   end

   // Storage is deliberately not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_char;
   end

   assign char_data  = mem[rd_ptr];
   assign char_valid = (count != '0);
   assign char_count = count;

endmodule

// File: tb/tb_char_in.sv
// Directed self-checking bench for char_in (DEPTH=16).
module tb_char_in;

   logic       clk;
   logic       resetn;
   logic [7:0] in_char;
   logic       in_strobe;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ack;
   logic [4:0] char_count;
   logic       overflow;
   logic       ovf_clear;

   int checks   = 0;
   int failures = 0;

   char_in #(.DEPTH(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_char    (in_char),
      .in_strobe  (in_strobe),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ack   (char_ack),
      .char_count (char_count),
      .overflow   (overflow),
      .ovf_clear  (ovf_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_char(input logic [7:0] c);
      in_strobe = 1'b0;
      tick();
      in_char   = c;
      in_strobe = 1'b1;
      tick();
      in_strobe = 1'b0;
   endtask

   task automatic pop_one();
      char_ack = 1'b1;
      tick();
      char_ack = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      checks++;
      if (char_valid !== 1'b1 || char_data !== exp) begin
         failures++;
         $display("FAIL %s valid=%b data=%h exp_data=%h", name, char_valid, char_data, exp);
      end
      pop_one();
   endtask

   task automatic test_reset();
      resetn = 1'b0; in_strobe = 1'b0; in_char = 8'h00; char_ack = 1'b0; ovf_clear = 1'b0;
      tick();
      checks++;
      if (char_valid !== 1'b0 || char_count !== 5'd0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state valid=%b count=%0d ovf=%b exp 0/0/0", char_valid, char_count, overflow);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      in_strobe = 1'b0;
      tick();
      in_char = 8'h41; in_strobe = 1'b1;
      tick();
      checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h41 || char_count !== 5'd1) begin
         failures++;
         $display("FAIL single_visible valid=%b data=%h count=%0d exp 1/41/1", char_valid, char_data, char_count);
      end
      repeat (4) tick();
      checks++;
      if (char_count !== 5'd1) begin
         failures++;
         $display("FAIL single_held_strobe count=%0d exp=1", char_count);
      end
      in_strobe = 1'b0;
      pop_one();
      checks++;
      if (char_valid !== 1'b0 || char_count !== 5'd0) begin
         failures++;
         $display("FAIL single_pop valid=%b count=%0d exp 0/0", char_valid, char_count);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] nxt;
      for (int i = 0; i < 10; i++) push_char(8'h30 + 8'(i));
      checks++;
      if (char_count !== 5'd10) begin
         failures++;
         $display("FAIL wrap_count10 count=%0d exp=10", char_count);
      end
      nxt = 8'h30;
      for (int i = 0; i < 6; i++) begin
         pop_expect("wrap_pop_a", nxt);
         nxt++;
      end
      for (int i = 0; i < 12; i++) push_char(8'h3A + 8'(i));
      checks++;
      if (char_count !== 5'd16 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL wrap_count16 count=%0d ovf=%b exp 16/0", char_count, overflow);
      end
      for (int i = 0; i < 16; i++) begin
         pop_expect("wrap_pop_b", nxt);
         nxt++;
      end
      checks++;
      if (char_count !== 5'd0 || char_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL wrap_empty count=%0d valid=%b ovf=%b exp 0/0/0", char_count, char_valid, overflow);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) push_char(8'(i));
      checks++;
      if (char_count !== 5'd16 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set count=%0d ovf=%b exp 16/1", char_count, overflow);
      end
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      checks++;
      if (overflow !== 1'b0 || char_count !== 5'd16) begin
         failures++;
         $display("FAIL ovf_clear ovf=%b count=%0d exp 0/16", overflow, char_count);
      end
      // drop while clearing: set must win
      in_strobe = 1'b0;
      tick();
      in_char = 8'hEE; in_strobe = 1'b1; ovf_clear = 1'b1;
      tick();
      in_strobe = 1'b0; ovf_clear = 1'b0;
      checks++;
      if (overflow !== 1'b1 || char_count !== 5'd16) begin
         failures++;
         $display("FAIL ovf_set_wins ovf=%b count=%0d exp 1/16", overflow, char_count);
      end
      for (int i = 0; i < 16; i++) pop_expect("ovf_pop", 8'(i));
      checks++;
      if (char_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_drained valid=%b exp=0", char_valid);
      end
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) push_char(8'h60 + 8'(i));
      in_strobe = 1'b0;
      tick();
      checks++;
      if (char_data !== 8'h60 || char_count !== 5'd16) begin
         failures++;
         $display("FAIL fpp_pre data=%h count=%0d exp 60/16", char_data, char_count);
      end
      in_char = 8'hAA; in_strobe = 1'b1; char_ack = 1'b1;
      tick();
      in_strobe = 1'b0; char_ack = 1'b0;
      checks++;
      if (char_count !== 5'd16 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL fpp_count count=%0d ovf=%b exp 16/0", char_count, overflow);
      end
      for (int i = 1; i < 16; i++) pop_expect("fpp_pop", 8'h60 + 8'(i));
      pop_expect("fpp_last", 8'hAA);
      checks++;
      if (char_valid !== 1'b0 || char_count !== 5'd0) begin
         failures++;
         $display("FAIL fpp_empty valid=%b count=%0d exp 0/0", char_valid, char_count);
      end
   endtask

   task automatic test_strobe_reset();
      resetn = 1'b0; in_strobe = 1'b1; in_char = 8'h99;
      tick();
      resetn = 1'b1;
      tick();
      tick();
      checks++;
      if (char_valid !== 1'b0 || char_count !== 5'd0) begin
         failures++;
         $display("FAIL strobe_reset_nocap valid=%b count=%0d exp 0/0", char_valid, char_count);
      end
      push_char(8'h55);
      checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h55 || char_count !== 5'd1) begin
         failures++;
         $display("FAIL strobe_reset_cap valid=%b data=%h count=%0d exp 1/55/1", char_valid, char_data, char_count);
      end
      pop_one();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) push_char(8'hC0 + 8'(i));
      checks++;
      if (char_count !== 5'd5) begin
         failures++;
         $display("FAIL mid_count5 count=%0d exp=5", char_count);
      end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (char_valid !== 1'b0 || char_count !== 5'd0) begin
         failures++;
         $display("FAIL mid_async valid=%b count=%0d exp 0/0", char_valid, char_count);
      end
      tick();
      resetn = 1'b1;
      tick();
      push_char(8'h77);
      checks++;
      if (char_valid !== 1'b1 || char_data !== 8'h77 || char_count !== 5'd1) begin
         failures++;
         $display("FAIL mid_after valid=%b data=%h count=%0d exp 1/77/1", char_valid, char_data, char_count);
      end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_overflow();
      test_full_push_pop();
      test_strobe_reset();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
